// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared constants for the VDP colour mixer slice
//
// Purpose: Game Gear LCD window bounds, CRAM geometry, RGB width and the
//          bit positions inside the sprite colour word.
//          in_range() is an inclusive unsigned range test used for the window flag.
package vdp_pkg;

  localparam logic [9:0] GG_X_START = 10'd48;
  localparam logic [9:0] GG_X_END   = 10'd207;
  localparam logic [9:0] GG_Y_START = 10'd24;
  localparam logic [9:0] GG_Y_END   = 10'd167;

  localparam int CRAM_ENTRIES = 32;
  localparam int CRAM_AW      = $clog2(CRAM_ENTRIES);
  localparam int RGB_W        = 12;

  // sprite_color layout: [5] palette, [4:1] index, [0] unused
  localparam int SPR_PAL_BIT = 5;
  localparam int SPR_IDX_MSB = 4;
  localparam int SPR_IDX_LSB = 1;

  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vdp_cram.sv
// rtl/vdp_cram.sv - 32x12 Game Gear colour RAM, one write and one read port
//
// Purpose: simple dual-port RAM with synchronous write and synchronous read.
//          A read and a write of the same entry on one edge return the old
//          contents; the new value appears on the following read.
//          Contents are not reset.
// Ports:
//   clk      in  clock
//   we       in  write enable
//   wr_addr  in  write entry
//   wr_data  in  12-bit colour to store
//   rd_addr  in  read entry
//   rd_data  out registered 12-bit colour
module vdp_cram
  import vdp_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [CRAM_AW-1:0] wr_addr,
  input  logic [RGB_W-1:0]   wr_data,
  input  logic [CRAM_AW-1:0] rd_addr,
  output logic [RGB_W-1:0]   rd_data
);

  logic [RGB_W-1:0] mem [CRAM_ENTRIES];

  // Both ports in one block so the read samples mem before this edge's write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vdp_color_mixer.sv
// rtl/vdp_color_mixer.sv - final VDP pixel stage: priority, CRAM lookup, CPU CRAM writes
//
// Purpose: resolves sprite/background priority and transparency, looks the
//          winning colour up in CRAM and presents 12-bit RGB two cycles later.
//          Also owns the CPU even/odd byte latch used to write CRAM.
// Ports:
//   clk, rst_n       pixel clock, synchronous active-low reset
//   pixel_x/pixel_y  current beam position
//   sprite_color     [5] palette, [4:1] index, index 0 = no sprite
//   bg_color         [4] palette, [3:0] index
//   bg_priority      background tile priority bit
//   display_en       0 forces backdrop
//   mask_col0        forces backdrop for pixel_x < 8
//   backdrop         backdrop index into the sprite palette half of CRAM
//   cram_we/cram_addr/cram_wdata  CPU byte write into CRAM
//   rgb              {B,G,R} for the pixel presented 2 cycles earlier
//   rgb_valid        that pixel lies inside the GG window
module vdp_color_mixer
  import vdp_pkg::*;
#(
  parameter logic [9:0] X_START = GG_X_START,
  parameter logic [9:0] X_END   = GG_X_END,
  parameter logic [9:0] Y_START = GG_Y_START,
  parameter logic [9:0] Y_END   = GG_Y_END
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic [5:0]       sprite_color,
  input  logic [4:0]       bg_color,
  input  logic             bg_priority,
  input  logic             display_en,
  input  logic             mask_col0,
  input  logic [3:0]       backdrop,
  input  logic             cram_we,
  input  logic [5:0]       cram_addr,
  input  logic [7:0]       cram_wdata,
  output logic [RGB_W-1:0] rgb,
  output logic             rgb_valid
);

  logic [3:0]         spr_idx;
  logic               spr_opaque;
  logic               bg_opaque;
  logic [CRAM_AW-1:0] sel_idx;
  logic               win;

  logic [CRAM_AW-1:0] idx_d;
  logic               win_d;
  logic               win_q;
  logic [RGB_W-1:0]   cram_q;

  logic [7:0]         latch;
  logic               cram_wr;

  // Palette bit of the sprite is implied (sprites always use the upper half);
  // the upper nibble of odd CRAM bytes has no storage.
  logic unused_bits;
  assign unused_bits = ^{sprite_color[SPR_PAL_BIT], sprite_color[0], cram_wdata[7:4]};

  assign spr_idx    = sprite_color[SPR_IDX_MSB:SPR_IDX_LSB];
  assign spr_opaque = |spr_idx;
  assign bg_opaque  = |bg_color[3:0];

  always_comb begin
    sel_idx = bg_color;
    if (!display_en || (mask_col0 && (pixel_x < 10'd8))) begin
      sel_idx = {1'b1, backdrop};
    end else if (spr_opaque && !(bg_priority && bg_opaque)) begin
      sel_idx = {1'b1, spr_idx};
    end
  end

  assign win = in_range(pixel_x, X_START, X_END) && in_range(pixel_y, Y_START, Y_END);

  // Stage 1: selected index and window flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_d <= '0;
      win_d <= 1'b0;
    end else begin
      idx_d <= sel_idx;
      win_d <= win;
    end
  end

  // Stage 2 valid; the colour itself is the RAM's registered read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q <= 1'b0;
    end else begin
      win_q <= win_d;
    end
  end

  // Even byte only loads the latch; it survives odd writes so the CPU can
  // rewrite just the blue nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch <= 8'h00;
    end else if (cram_we && !cram_addr[0]) begin
      latch <= cram_wdata;
    end
  end

  // Odd writes are not gated by reset: a CPU write landing on the reset
  // cycle still reaches CRAM, using the pre-reset latch.
  assign cram_wr = cram_we && cram_addr[0];

  vdp_cram u_cram (
    .clk     (clk),
    .we      (cram_wr),
    .wr_addr (cram_addr[5:1]),
    .wr_data ({cram_wdata[3:0], latch}),
    .rd_addr (idx_d),
    .rd_data (cram_q)
  );

  assign rgb       = win_q ? cram_q : '0;
  assign rgb_valid = win_q;

endmodule

// File: tb/tb_vdp_color_mixer.sv
// tb/tb_vdp_color_mixer.sv - scoreboard bench for vdp_color_mixer
module tb_vdp_color_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [5:0]  sprite_color;
  logic [4:0]  bg_color;
  logic        bg_priority;
  logic        display_en;
  logic        mask_col0;
  logic [3:0]  backdrop;
  logic        cram_we;
  logic [5:0]  cram_addr;
  logic [7:0]  cram_wdata;
  logic [11:0] rgb;
  logic        rgb_valid;

  vdp_color_mixer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .sprite_color (sprite_color),
    .bg_color     (bg_color),
    .bg_priority  (bg_priority),
    .display_en   (display_en),
    .mask_col0    (mask_col0),
    .backdrop     (backdrop),
    .cram_we      (cram_we),
    .cram_addr    (cram_addr),
    .cram_wdata   (cram_wdata),
    .rgb          (rgb),
    .rgb_valid    (rgb_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          ev;
    logic [11:0] er;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: the output seen after edge N belongs to the vector driven after edge N-2.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      if (mon_e.due != cyc || rgb_valid !== mon_e.ev || rgb !== mon_e.er) begin
        miscompares++;
        $display("FAIL %s: got rgb_valid=%0b rgb=%03h, expected rgb_valid=%0b rgb=%03h",
                 mon_e.nm, rgb_valid, rgb, mon_e.ev, mon_e.er);
      end
    end
  end

  task automatic tick(input bit ev, input logic [11:0] er, input string nm);
    exp_t e;
    e.due = cyc + 2;
    e.ev  = ev;
    e.er  = er;
    e.nm  = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [5:0] spr,
                     input logic [4:0] bg, input logic pri);
    pixel_x      = x;
    pixel_y      = y;
    sprite_color = spr;
    bg_color     = bg;
    bg_priority  = pri;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cram_we    = 1'b1;
    cram_addr  = a;
    cram_wdata = d;
  endtask

  task automatic nowr();
    cram_we    = 1'b0;
    cram_addr  = 6'd0;
    cram_wdata = 8'd0;
  endtask

  initial begin
    rst_n       = 1'b0;
    display_en  = 1'b1;
    mask_col0   = 1'b0;
    backdrop    = 4'd0;
    pix(0, 0, 6'h00, 5'h00, 1'b0);
    nowr();
    repeat (3) @(negedge clk);

    vectors++;
    if (rgb !== 12'h000 || rgb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rgb_valid=%0b rgb=%03h, expected rgb_valid=0 rgb=000",
               rgb_valid, rgb);
    end
    rst_n = 1'b1;

    // CRAM setup: e17=35A, e3=00F, e0=123 (upper nibble of A1 ignored), e18=7BC
    wr(34, 8'h5A); tick(0, 12'h000, "wr17_even");
    wr(35, 8'hF3); tick(0, 12'h000, "wr17_odd");
    wr(6,  8'h0F); tick(0, 12'h000, "wr3_even");
    wr(7,  8'h00); tick(0, 12'h000, "wr3_odd");
    wr(0,  8'h23); tick(0, 12'h000, "wr0_even");
    wr(1,  8'hA1); tick(0, 12'h000, "wr0_odd");
    wr(36, 8'hBC); tick(0, 12'h000, "wr18_even");
    wr(37, 8'h07); tick(0, 12'h000, "wr18_odd");
    nowr();

    pix(100, 50, 6'h22, 5'h00, 0); tick(1, 12'h35A, "sprite_e17");
    pix(100, 50, 6'h02, 5'h00, 0); tick(1, 12'h35A, "sprite_pal_bit_ignored");
    pix(100, 50, 6'h00, 5'h00, 0); tick(1, 12'h123, "bg_index0_reads_cram");

    pix(0, 0, 6'h00, 5'h00, 0);
    wr(34, 8'hF0); tick(0, 12'h000, "wr17b_even");
    wr(35, 8'h00); tick(0, 12'h000, "wr17b_odd");
    nowr();

    pix(100, 50, 6'h22, 5'h03, 1); tick(1, 12'h00F, "bg_priority_wins");
    pix(100, 50, 6'h22, 5'h03, 0); tick(1, 12'h0F0, "sprite_over_bg");
    pix(100, 50, 6'h22, 5'h10, 1); tick(1, 12'h0F0, "prio_bg_transparent");
    pix(100, 50, 6'h20, 5'h03, 0); tick(1, 12'h00F, "sprite_transparent");

    pix(47,  24,  6'h00, 5'h03, 0); tick(0, 12'h000, "x47");
    pix(48,  24,  6'h00, 5'h03, 0); tick(1, 12'h00F, "x48");
    pix(207, 24,  6'h00, 5'h03, 0); tick(1, 12'h00F, "x207");
    pix(208, 24,  6'h00, 5'h03, 0); tick(0, 12'h000, "x208");
    pix(100, 23,  6'h00, 5'h03, 0); tick(0, 12'h000, "y23");
    pix(100, 168, 6'h00, 5'h03, 0); tick(0, 12'h000, "y168");
    pix(100, 167, 6'h00, 5'h03, 0); tick(1, 12'h00F, "y167");

    backdrop = 4'h2; display_en = 1'b0;
    pix(100, 50, 6'h22, 5'h03, 0); tick(1, 12'h7BC, "display_off_backdrop");
    display_en = 1'b1; mask_col0 = 1'b1;
    pix(5,   50, 6'h22, 5'h03, 0); tick(0, 12'h000, "mask_col0_x5");
    pix(100, 50, 6'h22, 5'h03, 0); tick(1, 12'h0F0, "mask_col0_x100");
    mask_col0 = 1'b0; backdrop = 4'h0;

    // Read-before-write on entry 17
    pix(100, 50, 6'h22, 5'h00, 0);
    wr(34, 8'h66); tick(1, 12'h0F0, "rbw_old_value");
    wr(35, 8'h0C); tick(1, 12'hC66, "rbw_new_value");
    nowr();
    pix(0, 0, 6'h00, 5'h00, 0); tick(0, 12'h000, "idle");

    // Mid-line reset; odd write on the reset cycle uses pre-reset latch (0x66)
    pix(100, 50, 6'h22, 5'h00, 0); tick(0, 12'h000, "flushed_by_reset");
    rst_n = 1'b0; wr(41, 8'h09);    tick(0, 12'h000, "in_reset");
    rst_n = 1'b1; nowr();           tick(1, 12'hC66, "cram_retained");
    pix(0, 0, 6'h00, 5'h00, 0);
    wr(39, 8'h05); tick(0, 12'h000, "odd_after_reset");
    nowr();
    pix(100, 50, 6'h00, 5'h13, 0); tick(1, 12'h500, "latch_cleared_by_reset");
    pix(100, 50, 6'h00, 5'h14, 0); tick(1, 12'h966, "write_during_reset");
    pix(0, 0, 6'h00, 5'h00, 0);
    tick(0, 12'h000, "drain0");
    tick(0, 12'h000, "drain1");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: no output observed, expected rgb_valid=%0b rgb=%03h",
               mon_e.nm, mon_e.ev, mon_e.er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
